i2c_arbiter: RTL
================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one I2C byte controller (2..8).
REQ-002 Parameter LAUNCH_TIMEOUT, default 255, max I_clk cycles O_m_start is held waiting for I_m_busy to rise.
REQ-003 Parameter XFER_TIMEOUT, default 65535, max I_clk cycles waiting for I_m_busy to fall.
REQ-004 I_clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 I_reset  input  1  reset, synchronous, active-high.
REQ-006 I_req  input  NUM_REQ  per-requester transaction request, level, held until O_done bit.
REQ-007 I_wr  input  NUM_REQ  per-requester write-type request.
REQ-008 I_rd  input  NUM_REQ  per-requester read-type request.
REQ-009 I_wdata  input  8*NUM_REQ  per-requester write byte; requester k uses bits [8k+7:8k].
REQ-010 O_grant  output  NUM_REQ  one-hot owner of controller, zero when free.
REQ-011 O_done  output  NUM_REQ  one-cycle completion pulse to owner.
REQ-012 O_err  output  1  one-cycle pulse with O_done when transaction timed out.
REQ-013 O_rdata  output  8  last read byte, valid from O_done pulse until next read completes.
REQ-014 O_m_start, O_m_we, O_m_re  output  1 each  start/write-enable/read-enable to controller.
REQ-015 O_m_data  output  8  byte to controller.
REQ-016 I_m_data  input  8  byte read from controller; I_m_busy  input  1  controller busy.

Function
REQ-017 States SHALL be IDLE, LAUNCH, XFER, DONE; encoding from shared package.
REQ-018 IDLE: if any I_req bit has I_wr or I_rd set, select winner round-robin starting at pointer, go LAUNCH next cycle; requests with neither I_wr nor I_rd are ignored.
REQ-019 Entering LAUNCH: O_grant set to winner, O_m_data latched from winner's I_wdata slice, O_m_we=I_wr[k], O_m_re=I_rd[k] & ~I_wr[k] (write wins if both).
REQ-020 LAUNCH: O_m_start, O_m_we/O_m_re, O_m_data held constant; go XFER on first cycle I_m_busy=1.
REQ-021 LAUNCH: counter reaching LAUNCH_TIMEOUT with I_m_busy=0 -> DONE with error flag set.
REQ-022 XFER: O_m_start, O_m_we, O_m_re deasserted; on I_m_busy=0 go DONE; counter reaching XFER_TIMEOUT -> DONE with error.
REQ-023 DONE (one cycle): O_done[k]=1, O_err=error flag, O_rdata<=I_m_data if read and no error, O_grant cleared, pointer<=(k+1) mod NUM_REQ, -> IDLE.
REQ-024 Request-to-start latency: exactly 1 cycle from I_req sampled in IDLE to O_m_start=1.
REQ-025 Requester deasserting I_req after grant SHALL NOT abort; transaction completes and O_done still pulses.
REQ-026 Changes to I_wdata/I_wr/I_rd after grant SHALL NOT affect the current transaction.
REQ-027 Timeout counter clears on every state entry; width ceil(log2(XFER_TIMEOUT+1)).
REQ-028 Back-to-back: a requester still requesting after O_done is eligible again only after all other active requesters are served.
REQ-029 O_grant one-hot or zero in every cycle; at most one O_done bit per cycle.

Reset
REQ-030 On I_reset=1 at clock edge: state=IDLE, pointer=0, counter=0, O_grant=0, O_done=0, O_err=0, O_rdata=0, O_m_start=0, O_m_we=0, O_m_re=0, O_m_data=0.
REQ-031 Reset mid-transaction SHALL abandon it without O_done pulse; reset has priority over all events.

Structure
REQ-032 Package i2c_pkg SHALL hold state encoding, default NUM_REQ and timeout constants.
REQ-033 Sub-module rr_picker (combinational round-robin one-hot selector, NUM_REQ parameter) is the natural split; remainder in i2c_arbiter.

Verification
REQ-034 Single write: I_req=0001, I_wr=0001, I_wdata[7:0]=0xA5, busy rises 3 cycles later, falls 40 later -> O_m_data=0xA5, O_m_we=1, O_done=0001, O_err=0.
REQ-035 Read: requester 2, I_m_data=0x3C at busy fall -> O_rdata=0x3C, O_done=0100.
REQ-036 Fairness: I_req=1111 held, all writes -> grant order 0001,0010,0100,1000,0001.
REQ-037 Launch timeout: I_m_busy held 0 -> O_m_start high 255 cycles, then O_done and O_err pulse together.
REQ-038 Reset asserted during XFER -> next cycle all outputs at reset values, no O_done pulse.
REQ-039 Both I_wr and I_rd set, requester 1 -> O_m_we=1, O_m_re=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C requester arbiter: FSM encoding,
// default sizing and a round-robin index helper.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_XFER   = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  localparam int DEFAULT_NUM_REQ        = 4;
  localparam int DEFAULT_LAUNCH_TIMEOUT = 255;
  localparam int DEFAULT_XFER_TIMEOUT   = 65535;

  // Requester index reached after stepping 'offset' places from 'base',
  // wrapping at 'num'.
  function automatic int rr_index(input int base, input int offset, input int num);
    return (base + offset) % num;
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// Combinational round-robin selector: scans the request vector starting
// at the pointer and returns the first set bit as one-hot plus index.
module rr_picker
  import i2c_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  // First eligible requester at or after the pointer wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && req[rr_index(int'(ptr), i, NUM_REQ)]) begin
        gnt_vld = 1'b1;
        gnt_oh[rr_index(int'(ptr), i, NUM_REQ)] = 1'b1;
        gnt_idx = IDX_W'(rr_index(int'(ptr), i, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C byte controller among NUM_REQ requesters. A winner is
// picked round-robin, its command is latched and launched, and the owner
// gets a one-cycle done pulse (with error flag on timeout).
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int LAUNCH_TIMEOUT = DEFAULT_LAUNCH_TIMEOUT,
  parameter int XFER_TIMEOUT   = DEFAULT_XFER_TIMEOUT
) (
  input  logic                 I_clk,
  input  logic                 I_reset,
  input  logic [NUM_REQ-1:0]   I_req,
  input  logic [NUM_REQ-1:0]   I_wr,
  input  logic [NUM_REQ-1:0]   I_rd,
  input  logic [8*NUM_REQ-1:0] I_wdata,
  output logic [NUM_REQ-1:0]   O_grant,
  output logic [NUM_REQ-1:0]   O_done,
  output logic                 O_err,
  output logic [7:0]           O_rdata,
  output logic                 O_m_start,
  output logic                 O_m_we,
  output logic                 O_m_re,
  output logic [7:0]           O_m_data,
  input  logic [7:0]           I_m_data,
  input  logic                 I_m_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(XFER_TIMEOUT + 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic               rd_q;
  logic               timeout_hit;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;

  // A request only counts if it names a transfer type.
  assign eligible = I_req & (I_wr | I_rd);

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Next-state decode, including launch and transfer timeouts.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (I_m_busy) begin
          state_d = ST_XFER;
        end else if (cnt_q == CNT_W'(LAUNCH_TIMEOUT - 1)) begin
          state_d     = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_XFER: begin
        if (!I_m_busy) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(XFER_TIMEOUT - 1)) begin
          state_d     = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and timeout counter; the counter restarts on every
  // state change so each waiting phase is timed from its own entry.
  always_ff @(posedge I_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    if (I_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == ST_LAUNCH || state_q == ST_XFER)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered outputs: latch the winner's command on launch, drop the
  // strobes once the controller responds, pulse done/err on completion.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      O_grant   <= '0;
      O_done    <= '0;
      O_err     <= 1'b0;
      O_rdata   <= '0;
      O_m_start <= 1'b0;
      O_m_we    <= 1'b0;
      O_m_re    <= 1'b0;
      O_m_data  <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      rd_q      <= 1'b0;
    end else begin
      O_done <= '0;
      O_err  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            O_grant   <= pick_oh;
            owner_q   <= pick_idx;
            O_m_data  <= I_wdata[8*int'(pick_idx) +: 8];
            O_m_we    <= I_wr[pick_idx];
            O_m_re    <= I_rd[pick_idx] & ~I_wr[pick_idx];
            rd_q      <= I_rd[pick_idx] & ~I_wr[pick_idx];
            O_m_start <= 1'b1;
          end
        end
        ST_LAUNCH, ST_XFER: begin
          if (state_d != state_q) begin
            O_m_start <= 1'b0;
            O_m_we    <= 1'b0;
            O_m_re    <= 1'b0;
          end
          if (state_d == ST_DONE) begin
            O_done <= O_grant;
            O_err  <= timeout_hit;
            if (rd_q && !timeout_hit) O_rdata <= I_m_data;
          end
        end
        ST_DONE: begin
          O_grant <= '0;
          if (int'(owner_q) == NUM_REQ - 1) ptr_q <= '0;
          else                              ptr_q <= owner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
